// File: rtl/vlsu_pkg.sv
// Shared types, sizes and the lane/offset -> sequential nibble index map
// for the matrix store deshuffle path.
package vlsu_pkg;

  localparam int unsigned DLEN       = 16;
  localparam int unsigned NrExits    = 4;
  localparam int unsigned NbPerLane  = DLEN / 4;
  localparam int unsigned NbTotal    = NrExits * NbPerLane;
  localparam int unsigned IdxW       = $clog2(NbTotal);
  localparam int unsigned LogNbLane  = $clog2(NbPerLane);
  localparam int unsigned InfoBufDep = 4;
  localparam int unsigned NrVInsn    = 8;
  localparam int unsigned ReqIdW     = $clog2(NrVInsn);
  localparam int unsigned CmtCntW    = 4;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef logic [ReqIdW-1:0] req_id_t;

  typedef struct packed {
    req_id_t              req_id;
    sew_e                 sew;
    logic                 vm;
    logic [CmtCntW-1:0]   cmt_cnt;
    logic                 md;
    logic [1:0]           mode;
  } meta_glb_t;

  typedef struct packed {
    req_id_t              req_id;
    sew_e                 sew;
    logic                 vm;
    logic [CmtCntW-1:0]   cmt_cnt;
  } store_info_t;

  typedef struct packed {
    req_id_t                 req_id;
    logic [NbPerLane*4-1:0]  data;
    logic [NbPerLane-1:0]    nbe;
  } rx_lane_t;

  typedef struct packed {
    logic [NbTotal*4-1:0]  nb;
    logic [NbTotal-1:0]    en;
  } seq_buf_t;

  typedef struct packed {
    logic [NrVInsn-1:0]  vinsn_done;
  } pe_resp_t;

  // Elements are spread round-robin over the lanes; an element wider than a
  // lane beat is split into lane-beat-sized chunks that follow the same rule.
  function automatic int unsigned query_seq_idx_2d_cln(input int unsigned nr_exits,
                                                       input int unsigned idx,
                                                       input sew_e        sew);
    int unsigned ew;
    int unsigned lane;
    int unsigned off;
    ew = 32'(sew) + 32'd1;
    if (ew > LogNbLane) ew = LogNbLane;
    lane = idx / NbPerLane;
    off  = idx % NbPerLane;
    return ((((off >> ew) * nr_exits) + lane) << ew) | (off & ((32'd1 << ew) - 32'd1));
  endfunction

endpackage

// File: rtl/circular_queue_ptr.sv
// Wrap-flag circular pointer: value counts 0..Depth-1, flag toggles on wrap.
module circular_queue_ptr #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_inc,
  output logic                     o_flag,
  output logic [$clog2(Depth)-1:0] o_value
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic            r_flag;
  logic [PtrW-1:0] r_value;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flag  <= 1'b0;
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= r_value + PtrW'(1);
      if (r_value == PtrW'(Depth - 1)) r_flag <= ~r_flag;
    end
  end

  assign o_flag  = r_flag;
  assign o_value = r_value;

endmodule

// File: rtl/m_deshuffle_xbar.sv
// Inverse lane/offset permutation into sequential nibble order, with byte
// enables gated by the mask unless the store is unmasked.
module m_deshuffle_xbar
  import vlsu_pkg::*;
(
  input  sew_e                              i_sew,
  input  logic                              i_vm,
  input  rx_lane_t                          i_slots [NrExits],
  input  logic [NrExits-1:0][NbPerLane-1:0] i_mask_bits,
  output seq_buf_t                          o_seq
);

  always_comb begin
    logic [IdxW-1:0] s;
    o_seq = '0;
    s     = '0;
    for (int unsigned l = 0; l < NrExits; l++) begin
      for (int unsigned o = 0; o < NbPerLane; o++) begin
        s = IdxW'(query_seq_idx_2d_cln(NrExits, l * NbPerLane + o, i_sew));
        o_seq.nb[{s, 2'b00} +: 4] = i_slots[l].data[o*4 +: 4];
        o_seq.en[s] = i_slots[l].nbe[o] & (i_vm | i_mask_bits[l][o]);
      end
    end
  end

endmodule

// File: rtl/m_deshuffle_unit.sv
// Store-path deshuffle: collects one beat per lane, reorders into sequential
// nibbles, masks, emits one beat per commit and retires vinsns via pe_resp.
module m_deshuffle_unit
  import vlsu_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              meta_info_valid_i,
  output logic                              meta_info_ready_o,
  input  meta_glb_t                         meta_info_i,
  input  logic [NrExits-1:0]                rxs_valid_i,
  output logic [NrExits-1:0]                rxs_ready_o,
  input  rx_lane_t                          rxs_i [NrExits],
  input  logic [NrExits-1:0]                mask_valid_i,
  input  logic [NrExits-1:0][NbPerLane-1:0] mask_bits_i,
  output logic                              mask_ready_o,
  output logic                              tx_seq_store_valid_o,
  input  logic                              tx_seq_store_ready_i,
  output seq_buf_t                          tx_seq_store_o,
  output pe_resp_t                          pe_resp_store_o
);

  localparam int unsigned PtrW = $clog2(InfoBufDep);

  // All interfaces are valid/ready: a transfer happens on a cycle where both
  // are high; a valid producer holds its payload stable until accepted.

  store_info_t          r_info [InfoBufDep];
  rx_lane_t             r_slot [NrExits];
  logic [NrExits-1:0]   r_slot_valid;
  logic                 r_tx_valid;
  seq_buf_t             r_tx_data;

  logic                 w_enq_flag, w_deq_flag;
  logic [PtrW-1:0]      w_enq_idx, w_deq_idx;
  logic                 w_empty, w_full, w_enq, w_deq, w_commit, w_last;
  store_info_t          w_head;
  seq_buf_t             w_xbar_out;

  circular_queue_ptr #(.Depth(InfoBufDep)) u_enq_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_inc   (w_enq),
    .o_flag  (w_enq_flag),
    .o_value (w_enq_idx)
  );

  circular_queue_ptr #(.Depth(InfoBufDep)) u_deq_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_inc   (w_deq),
    .o_flag  (w_deq_flag),
    .o_value (w_deq_idx)
  );

  assign w_empty  = (w_enq_idx == w_deq_idx) && (w_enq_flag == w_deq_flag);
  assign w_full   = (w_enq_idx == w_deq_idx) && (w_enq_flag != w_deq_flag);
  assign w_head   = r_info[w_deq_idx];
  assign w_enq    = meta_info_valid_i && !w_full;
  assign w_commit = (&r_slot_valid) && !w_empty && (w_head.vm || (&mask_valid_i))
                    && (!r_tx_valid || tx_seq_store_ready_i);
  assign w_last   = (w_head.cmt_cnt == '0);
  assign w_deq    = w_commit && w_last;

  assign meta_info_ready_o    = !w_full;
  assign mask_ready_o         = w_commit && !w_head.vm;
  assign rxs_ready_o          = ~r_slot_valid | {NrExits{w_commit}};
  assign tx_seq_store_valid_o = r_tx_valid;
  assign tx_seq_store_o       = r_tx_data;

  always_comb begin
    pe_resp_store_o = '0;
    if (w_deq) pe_resp_store_o.vinsn_done[w_head.req_id] = 1'b1;
  end

  // Enqueue and head update never alias: a shared index means empty (no
  // commit) or full (no enqueue).
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_info[w_enq_idx].req_id  <= meta_info_i.req_id;
      r_info[w_enq_idx].sew     <= meta_info_i.sew;
      r_info[w_enq_idx].vm      <= meta_info_i.vm;
      r_info[w_enq_idx].cmt_cnt <= meta_info_i.cmt_cnt;
    end
    if (w_commit && !w_last) r_info[w_deq_idx].cmt_cnt <= w_head.cmt_cnt - CmtCntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_slot_valid <= '0;
    end else begin
      for (int l = 0; l < NrExits; l++) begin
        if (rxs_valid_i[l] && rxs_ready_o[l]) r_slot_valid[l] <= 1'b1;
        else if (w_commit)                    r_slot_valid[l] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NrExits; l++) begin
      if (rxs_valid_i[l] && rxs_ready_o[l]) r_slot[l] <= rxs_i[l];
    end
  end

  m_deshuffle_xbar u_xbar (
    .i_sew       (w_head.sew),
    .i_vm        (w_head.vm),
    .i_slots     (r_slot),
    .i_mask_bits (mask_bits_i),
    .o_seq       (w_xbar_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_commit) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_xbar_out;
    end else if (tx_seq_store_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  for (genvar l = 0; l < NrExits; l++) begin : g_chk
    a_slot_req_id: assert property (@(posedge clk_i) disable iff (rst_i)
      w_commit |-> (r_slot[l].req_id == w_head.req_id));
  end

  a_rx_needs_info: assert property (@(posedge clk_i) disable iff (rst_i)
    (|rxs_valid_i) |-> !w_empty);

endmodule
